// File: rtl/cpu_pkg.sv
// Purpose : shared types and constants for the fetch/execute pipeline.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: INST_W, RESET_PC_DEFAULT, PC_STEP, OPC_W, fetch_entry_t, align_pc().
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int OPC_W  = 7;

  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] PC_STEP          = 32'd4;

  // One fetched instruction together with the address it was read from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc;
  } fetch_entry_t;

  // Fetch targets are always word aligned; the low two bits are discarded.
  function automatic logic [INST_W-1:0] align_pc(input logic [INST_W-1:0] a);
    return a & ~(INST_W'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Purpose : 2-entry FIFO of fetch_entry_t with push, pop and flush (flush wins over push).
// Latency : push visible at head the cycle after the push edge; pop frees the head on the edge.
// Backpr. : no internal stall; the producer must never push into a full queue without a pop.
// Ports   : clock, reset (async, high); push/push_data in; pop in; flush in;
//           count (0..2) and head (zero when empty) out.
module fetch_fifo2
  import cpu_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  // slot0 is always the head; slot1 is only meaningful when count == 2.
  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop & (count != 2'd0);
  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_push = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = (count != 2'd0) ? slot0 : '0;

endmodule

// File: rtl/s1_fetch.sv
// Purpose : instruction-fetch stage; owns the PC, reads a 1-cycle synchronous imem,
//           queues words in a 2-entry FIFO and hands {inst, pc, opc} to s2.
// Latency : request in cycle N -> out_valid in cycle N+2; 1 instruction/cycle sustained.
// Backpr. : out_ready low stops new requests once queue + in-flight reach 2; head held stable.
// Ports   : clock, reset (async, high); imem_req/imem_addr out, imem_rdata in;
//           out_valid/out_inst/out_pc/out_opc out, out_ready in; redirect/redirect_pc in.
module s1_fetch
  import cpu_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [INST_W-1:0] out_pc,
  output logic [OPC_W-1:0]  out_opc,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_pc
);

  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] tag_pc;     // address of the read currently in flight
  logic              inflight;
  logic [1:0]        count;
  logic              pop;
  logic              push;
  logic [2:0]        credit;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign pop = out_valid & out_ready;

  // Slots already committed after this edge: queued entries plus the word
  // arriving, minus the one s2 takes now. Keeping this below 2 before issuing
  // means the returning word always has a slot.
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign imem_req  = !reset && !redirect && (credit < 3'd2);
  assign imem_addr = pc;

  // A redirect kills the returning word: it belongs to the abandoned path.
  assign push       = inflight & !redirect;
  assign push_entry = '{inst: imem_rdata, pc: tag_pc};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= align_pc(redirect_pc);
      inflight <= 1'b0;
    end else if (imem_req) begin
      pc       <= pc + PC_STEP;
      tag_pc   <= pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo2 u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign out_valid = (count != 2'd0);
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign out_opc   = head.inst[OPC_W-1:0];

endmodule
